// File: rtl/vector_memory_stage.sv
// rtl/vector_memory_stage.sv - MEM stage that splits vector loads/stores into narrow RAM beats
// and emits one registered writeback bundle per retired op.
module vector_memory_stage #(
  parameter int ADDR_W   = 12,
  parameter int SCALAR_W = 8,
  parameter int VEC_W    = 128,
  parameter int BEAT_W   = 32,
  parameter int RD_W     = 5
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                flush,
  input  logic                ex_valid,
  output logic                ex_ready,
  input  logic [2:0]          ex_op,
  input  logic [ADDR_W-1:0]   ex_addr,
  input  logic [SCALAR_W-1:0] ex_sdata,
  input  logic [VEC_W-1:0]    ex_vdata,
  input  logic [RD_W-1:0]     ex_rd,
  input  logic                ex_wre,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [BEAT_W-1:0]   mem_wdata,
  output logic                mem_we,
  input  logic [BEAT_W-1:0]   mem_rdata,
  output logic                wb_valid,
  output logic [RD_W-1:0]     wb_rd,
  output logic                wb_wre,
  output logic                wb_vwre,
  output logic [SCALAR_W-1:0] wb_sdata,
  output logic [VEC_W-1:0]    wb_vdata
);
  localparam int BEATS = VEC_W / BEAT_W;
  localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [2:0] OP_ALU_S = 3'd0;
  localparam logic [2:0] OP_ALU_V = 3'd1;
  localparam logic [2:0] OP_LD_S  = 3'd2;
  localparam logic [2:0] OP_ST_S  = 3'd3;
  localparam logic [2:0] OP_LD_V  = 3'd4;
  localparam logic [2:0] OP_ST_V  = 3'd5;

  typedef enum logic [2:0] {S_IDLE, S_SLD, S_VLD, S_VST, S_VDRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [VEC_W-1:0]    vdata_q, vdata_d;
  logic [RD_W-1:0]     rd_q, rd_d;
  logic                wre_q, wre_d;
  logic [2:0]          op_q, op_d;
  logic [CNT_W-1:0]    beat_q, beat_d;
  logic [VEC_W-1:0]    buf_q, buf_d;
  logic                wb_valid_q, wb_valid_d;
  logic [RD_W-1:0]     wb_rd_q, wb_rd_d;
  logic                wb_wre_q, wb_wre_d;
  logic                wb_vwre_q, wb_vwre_d;
  logic [SCALAR_W-1:0] wb_sdata_q, wb_sdata_d;
  logic [VEC_W-1:0]    wb_vdata_q, wb_vdata_d;
  logic                xfer;
  logic [CNT_W-1:0]    last_beat;

  assign last_beat = CNT_W'(BEATS - 1);

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    vdata_d    = vdata_q;
    rd_d       = rd_q;
    wre_d      = wre_q;
    op_d       = op_q;
    beat_d     = beat_q;
    buf_d      = buf_q;
    wb_valid_d = 1'b0;
    wb_wre_d   = 1'b0;
    wb_vwre_d  = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_sdata_d = wb_sdata_q;
    wb_vdata_d = wb_vdata_q;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    ex_ready   = (state_q == S_IDLE) && !flush;
    xfer       = ex_ready && ex_valid;

    case (state_q)
      S_IDLE: begin
        if (xfer) begin
          addr_d  = ex_addr;
          vdata_d = ex_vdata;
          rd_d    = ex_rd;
          wre_d   = ex_wre;
          op_d    = ex_op;
          beat_d  = CNT_W'(1);
          case (ex_op)
            OP_ALU_S: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
              wb_sdata_d = ex_sdata;
              wb_wre_d   = ex_wre;
            end
            OP_ALU_V: begin
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
              wb_vdata_d = ex_vdata;
              wb_vwre_d  = ex_wre;
            end
            OP_LD_S: begin
              mem_addr = ex_addr;
              state_d  = S_SLD;
            end
            OP_ST_S: begin
              mem_addr   = ex_addr;
              mem_we     = 1'b1;
              mem_wdata  = BEAT_W'(ex_sdata);
              wb_valid_d = 1'b1;
              wb_rd_d    = ex_rd;
            end
            OP_LD_V: begin
              mem_addr = ex_addr;
              state_d  = (BEATS == 1) ? S_SLD : S_VLD;
            end
            OP_ST_V: begin
              mem_addr  = ex_addr;
              mem_we    = 1'b1;
              mem_wdata = ex_vdata[BEAT_W-1:0];
              if (BEATS == 1) begin
                wb_valid_d = 1'b1;
                wb_rd_d    = ex_rd;
              end else begin
                state_d = S_VST;
              end
            end
            default: ;
          endcase
        end
      end
      S_SLD: begin
        // Single-beat vector loads share this state and write the vector file instead.
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        if (op_q == OP_LD_V) begin
          wb_vdata_d = VEC_W'(mem_rdata);
          wb_vwre_d  = wre_q;
        end else begin
          wb_sdata_d = mem_rdata[SCALAR_W-1:0];
          wb_wre_d   = wre_q;
        end
        state_d = S_IDLE;
      end
      S_VLD: begin
        mem_addr = addr_q + ADDR_W'(beat_q);
        buf_d[int'(beat_q - 1'b1)*BEAT_W +: BEAT_W] = mem_rdata;
        if (beat_q == last_beat) state_d = S_VDRAIN;
        else                     beat_d  = beat_q + 1'b1;
      end
      S_VDRAIN: begin
        buf_d[(BEATS-1)*BEAT_W +: BEAT_W] = mem_rdata;
        wb_vdata_d = buf_d;
        wb_vwre_d  = wre_q;
        wb_valid_d = 1'b1;
        wb_rd_d    = rd_q;
        state_d    = S_IDLE;
      end
      S_VST: begin
        mem_addr  = addr_q + ADDR_W'(beat_q);
        mem_we    = 1'b1;
        mem_wdata = vdata_q[int'(beat_q)*BEAT_W +: BEAT_W];
        if (beat_q == last_beat) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          state_d    = S_IDLE;
        end else begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A squashed op never retires and never writes; beats already written stay written.
    if (flush || reset) begin
      state_d    = S_IDLE;
      mem_we     = 1'b0;
      wb_valid_d = 1'b0;
      wb_wre_d   = 1'b0;
      wb_vwre_d  = 1'b0;
      wb_rd_d    = wb_rd_q;
      wb_sdata_d = wb_sdata_q;
      wb_vdata_d = wb_vdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      vdata_q    <= '0;
      rd_q       <= '0;
      wre_q      <= 1'b0;
      op_q       <= '0;
      beat_q     <= '0;
      buf_q      <= '0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= '0;
      wb_wre_q   <= 1'b0;
      wb_vwre_q  <= 1'b0;
      wb_sdata_q <= '0;
      wb_vdata_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      vdata_q    <= vdata_d;
      rd_q       <= rd_d;
      wre_q      <= wre_d;
      op_q       <= op_d;
      beat_q     <= beat_d;
      buf_q      <= buf_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_wre_q   <= wb_wre_d;
      wb_vwre_q  <= wb_vwre_d;
      wb_sdata_q <= wb_sdata_d;
      wb_vdata_q <= wb_vdata_d;
    end
  end

  assign wb_valid = wb_valid_q;
  assign wb_rd    = wb_rd_q;
  assign wb_wre   = wb_wre_q;
  assign wb_vwre  = wb_vwre_q;
  assign wb_sdata = wb_sdata_q;
  assign wb_vdata = wb_vdata_q;

endmodule

// File: tb/tb_vector_memory_stage.sv
// tb/tb_vector_memory_stage.sv - directed bench for vector_memory_stage with a registered-read RAM model.
module tb_vector_memory_stage;
  logic         clk = 1'b0;
  logic         reset, flush, ex_valid, ex_ready, ex_wre, mem_we;
  logic [2:0]   ex_op;
  logic [11:0]  ex_addr, mem_addr;
  logic [7:0]   ex_sdata, wb_sdata;
  logic [127:0] ex_vdata, wb_vdata;
  logic [4:0]   ex_rd, wb_rd;
  logic [31:0]  mem_wdata, mem_rdata;
  logic         wb_valid, wb_wre, wb_vwre;
  logic [31:0]  ram [0:4095];
  logic [11:0]  addr_log [0:15];
  int           pass_cnt = 0;
  int           total_cnt = 0;
  int           cyc, lo;
  logic         seen;

  localparam logic [127:0] V1   = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] V2   = 128'hDDDD0004_CCCC0003_BBBB0002_AAAA0001;
  localparam logic [127:0] V3   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
  localparam logic [127:0] OLDV = 128'h0F0F0F04_0F0F0F03_0F0F0F02_0F0F0F01;
  localparam logic [127:0] NEWV = 128'hA5A50004_A5A50003_A5A50002_A5A50001;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  vector_memory_stage dut (
    .clk(clk), .reset(reset), .flush(flush), .ex_valid(ex_valid), .ex_ready(ex_ready),
    .ex_op(ex_op), .ex_addr(ex_addr), .ex_sdata(ex_sdata), .ex_vdata(ex_vdata),
    .ex_rd(ex_rd), .ex_wre(ex_wre), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_we(mem_we), .mem_rdata(mem_rdata), .wb_valid(wb_valid), .wb_rd(wb_rd),
    .wb_wre(wb_wre), .wb_vwre(wb_vwre), .wb_sdata(wb_sdata), .wb_vdata(wb_vdata)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ex_valid = 1'b0; ex_op = 3'd6; ex_addr = '0; ex_sdata = '0;
    ex_vdata = '0; ex_rd = '0; ex_wre = 1'b0;
  endtask

  task automatic issue(input logic [2:0] op, input logic [11:0] a, input logic [127:0] v,
                       input logic [7:0] s, input logic [4:0] r, input logic w);
    ex_valid = 1'b1; ex_op = op; ex_addr = a; ex_vdata = v; ex_sdata = s; ex_rd = r; ex_wre = w;
  endtask

  // Called in cycle C+1; cyc = k where retirement is seen in C+k, -1 on timeout.
  task automatic wait_wb(output int c, output int l);
    c = -1; l = 0;
    for (int k = 1; k <= 12; k++) begin
      addr_log[k] = mem_addr;
      if (!ex_ready) l++;
      if (wb_valid) begin c = k; break; end
      step();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; flush = 1'b0; idle_inputs();
    step(); step();
    reset = 1'b0;
    #1;
    total_cnt++;
    if ({ex_ready, wb_valid, wb_wre, wb_vwre, wb_rd, wb_sdata, wb_vdata} !== {1'b1, 144'd0})
      $display("FAIL reset_state got ready=%0b valid=%0b rd=%0h sdata=%0h vdata=%0h exp ready=1 rest 0",
               ex_ready, wb_valid, wb_rd, wb_sdata, wb_vdata);
    else pass_cnt++;
  endtask

  task automatic test_alu_s();
    issue(3'd0, 12'h000, 128'd0, 8'h01, 5'd3, 1'b1);
    #1;
    total_cnt++;
    if ({ex_ready, mem_we, mem_addr, mem_wdata} !== {1'b1, 1'b0, 12'h000, 32'h0})
      $display("FAIL alu_s_accept got ready=%0b we=%0b addr=%0h wdata=%0h exp 1 0 0 0",
               ex_ready, mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    step(); idle_inputs();
    total_cnt++;
    if ({wb_valid, wb_rd, wb_sdata, wb_wre, wb_vwre} !== {1'b1, 5'd3, 8'h01, 1'b1, 1'b0})
      $display("FAIL alu_s_wb got valid=%0b rd=%0d sdata=%0h wre=%0b vwre=%0b exp 1 3 01 1 0",
               wb_valid, wb_rd, wb_sdata, wb_wre, wb_vwre);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({wb_valid, wb_wre, wb_sdata, wb_rd} !== {1'b0, 1'b0, 8'h01, 5'd3})
      $display("FAIL alu_s_hold got valid=%0b wre=%0b sdata=%0h rd=%0d exp 0 0 01 3",
               wb_valid, wb_wre, wb_sdata, wb_rd);
    else pass_cnt++;
  endtask

  task automatic test_flush_idle_and_bubble();
    issue(3'd0, 12'h000, 128'd0, 8'h77, 5'd6, 1'b1);
    flush = 1'b1;
    #1;
    total_cnt++;
    if ({ex_ready, mem_we} !== 2'b00)
      $display("FAIL flush_idle_ready got ready=%0b we=%0b exp 0 0", ex_ready, mem_we);
    else pass_cnt++;
    step(); flush = 1'b0; idle_inputs();
    total_cnt++;
    if ({wb_valid, wb_sdata, wb_rd} !== {1'b0, 8'h01, 5'd3})
      $display("FAIL flush_idle_noaccept got valid=%0b sdata=%0h rd=%0d exp 0 01 3", wb_valid, wb_sdata, wb_rd);
    else pass_cnt++;
    issue(3'd7, 12'h123, 128'd0, 8'h99, 5'd8, 1'b1);
    #1;
    total_cnt++;
    if ({ex_ready, mem_we, mem_addr} !== {1'b1, 1'b0, 12'h000})
      $display("FAIL bubble_port got ready=%0b we=%0b addr=%0h exp 1 0 000", ex_ready, mem_we, mem_addr);
    else pass_cnt++;
    step(); idle_inputs();
    total_cnt++;
    if ({wb_valid, ex_ready, wb_rd} !== {1'b0, 1'b1, 5'd3})
      $display("FAIL bubble_noretire got valid=%0b ready=%0b rd=%0d exp 0 1 3", wb_valid, ex_ready, wb_rd);
    else pass_cnt++;
  endtask

  task automatic test_alu_v();
    issue(3'd1, 12'h000, V3, 8'h00, 5'd10, 1'b1);
    step(); idle_inputs();
    total_cnt++;
    if ({wb_valid, wb_vwre, wb_wre, wb_rd, wb_vdata} !== {1'b1, 1'b1, 1'b0, 5'd10, V3})
      $display("FAIL alu_v_wb got valid=%0b vwre=%0b wre=%0b rd=%0d vdata=%0h exp 1 1 0 10 %0h",
               wb_valid, wb_vwre, wb_wre, wb_rd, wb_vdata, V3);
    else pass_cnt++;
  endtask

  task automatic test_scalar_mem();
    issue(3'd3, 12'h005, 128'd0, 8'h5A, 5'd2, 1'b1);
    #1;
    total_cnt++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h005, 32'h0000005A})
      $display("FAIL st_s_port got we=%0b addr=%0h wdata=%0h exp 1 005 0000005a", mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    step(); idle_inputs();
    total_cnt++;
    if ({wb_valid, wb_wre, wb_vwre, wb_rd} !== {1'b1, 1'b0, 1'b0, 5'd2})
      $display("FAIL st_s_wb got valid=%0b wre=%0b vwre=%0b rd=%0d exp 1 0 0 2", wb_valid, wb_wre, wb_vwre, wb_rd);
    else pass_cnt++;
    issue(3'd2, 12'h005, 128'd0, 8'h00, 5'd7, 1'b1);
    step(); idle_inputs();
    total_cnt++;
    if ({ex_ready, wb_valid} !== 2'b00)
      $display("FAIL ld_s_stall got ready=%0b valid=%0b exp 0 0", ex_ready, wb_valid);
    else pass_cnt++;
    step();
    total_cnt++;
    if ({wb_valid, wb_wre, wb_vwre, wb_rd, wb_sdata} !== {1'b1, 1'b1, 1'b0, 5'd7, 8'h5A})
      $display("FAIL ld_s_wb got valid=%0b wre=%0b vwre=%0b rd=%0d sdata=%0h exp 1 1 0 7 5a",
               wb_valid, wb_wre, wb_vwre, wb_rd, wb_sdata);
    else pass_cnt++;
  endtask

  task automatic test_vector_store_load();
    issue(3'd5, 12'h010, V1, 8'h00, 5'd4, 1'b1);
    #1;
    total_cnt++;
    if ({mem_we, mem_addr, mem_wdata} !== {1'b1, 12'h010, 32'h11111111})
      $display("FAIL st_v_beat0 got we=%0b addr=%0h wdata=%0h exp 1 010 11111111", mem_we, mem_addr, mem_wdata);
    else pass_cnt++;
    step(); idle_inputs();
    wait_wb(cyc, lo);
    total_cnt++;
    if (cyc !== 4 || lo !== 3 || {wb_wre, wb_vwre, wb_rd} !== {1'b0, 1'b0, 5'd4})
      $display("FAIL st_v_timing got retire=C+%0d stall=%0d wre=%0b vwre=%0b rd=%0d exp C+4 3 0 0 4",
               cyc, lo, wb_wre, wb_vwre, wb_rd);
    else pass_cnt++;
    total_cnt++;
    if ({ram[12'h010], ram[12'h011], ram[12'h012], ram[12'h013]} !==
        {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444})
      $display("FAIL st_v_ram got %0h %0h %0h %0h exp 11111111 22222222 33333333 44444444",
               ram[12'h010], ram[12'h011], ram[12'h012], ram[12'h013]);
    else pass_cnt++;
    step();
    issue(3'd4, 12'h010, 128'd0, 8'h00, 5'd9, 1'b1);
    step(); idle_inputs();
    wait_wb(cyc, lo);
    total_cnt++;
    if (cyc !== 5 || {wb_vwre, wb_wre, wb_rd} !== {1'b1, 1'b0, 5'd9} || wb_vdata !== V1)
      $display("FAIL ld_v_wb got retire=C+%0d vwre=%0b wre=%0b rd=%0d vdata=%0h exp C+5 1 0 9 %0h",
               cyc, wb_vwre, wb_wre, wb_rd, wb_vdata, V1);
    else pass_cnt++;
    step();
  endtask

  task automatic test_wrap();
    issue(3'd5, 12'hFFE, V2, 8'h00, 5'd1, 1'b0);
    step(); idle_inputs();
    wait_wb(cyc, lo);
    total_cnt++;
    if (cyc !== 4 || {ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]} !==
        {32'hAAAA0001, 32'hBBBB0002, 32'hCCCC0003, 32'hDDDD0004})
      $display("FAIL st_v_wrap got retire=C+%0d ram %0h %0h %0h %0h exp C+4 aaaa0001 bbbb0002 cccc0003 dddd0004",
               cyc, ram[12'hFFE], ram[12'hFFF], ram[12'h000], ram[12'h001]);
    else pass_cnt++;
    step();
    issue(3'd4, 12'hFFE, 128'd0, 8'h00, 5'd11, 1'b1);
    #1;
    addr_log[0] = mem_addr;
    step(); idle_inputs();
    wait_wb(cyc, lo);
    total_cnt++;
    if ({addr_log[0], addr_log[1], addr_log[2], addr_log[3]} !== {12'hFFE, 12'hFFF, 12'h000, 12'h001})
      $display("FAIL ld_v_wrap_addr got %0h %0h %0h %0h exp ffe fff 000 001",
               addr_log[0], addr_log[1], addr_log[2], addr_log[3]);
    else pass_cnt++;
    total_cnt++;
    if (cyc !== 5 || wb_vdata !== V2 || wb_rd !== 5'd11)
      $display("FAIL ld_v_wrap_data got retire=C+%0d vdata=%0h rd=%0d exp C+5 %0h 11", cyc, wb_vdata, wb_rd, V2);
    else pass_cnt++;
    step();
  endtask

  // use_reset selects reset instead of flush as the squash in cycle C+2.
  task automatic test_squash(input logic [11:0] base, input logic use_reset);
    issue(3'd5, base, OLDV, 8'h00, 5'd12, 1'b0);
    step(); idle_inputs();
    wait_wb(cyc, lo);
    step();
    issue(3'd5, base, NEWV, 8'h00, 5'd13, 1'b0);
    step(); idle_inputs();
    seen = wb_valid;
    step();
    seen = seen | wb_valid;
    if (use_reset) reset = 1'b1; else flush = 1'b1;
    #1;
    total_cnt++;
    if (mem_we !== 1'b0)
      $display("FAIL squash_we rst=%0b got we=%0b exp 0", use_reset, mem_we);
    else pass_cnt++;
    step();
    reset = 1'b0; flush = 1'b0;
    #1;
    total_cnt++;
    if (ex_ready !== 1'b1)
      $display("FAIL squash_ready rst=%0b got ready=%0b exp 1", use_reset, ex_ready);
    else pass_cnt++;
    if (use_reset) begin
      total_cnt++;
      if ({wb_valid, wb_wre, wb_vwre, wb_rd, wb_sdata, wb_vdata} !== 144'd0)
        $display("FAIL reset_clears_wb got valid=%0b rd=%0d sdata=%0h vdata=%0h exp all 0",
                 wb_valid, wb_rd, wb_sdata, wb_vdata);
      else pass_cnt++;
    end
    for (int k = 0; k < 3; k++) begin
      seen = seen | wb_valid;
      step();
    end
    total_cnt++;
    if (seen !== 1'b0)
      $display("FAIL squash_noretire rst=%0b got wb_valid seen=%0b exp 0", use_reset, seen);
    else pass_cnt++;
    total_cnt++;
    if ({ram[base], ram[base+12'd1], ram[base+12'd2], ram[base+12'd3]} !==
        {NEWV[31:0], NEWV[63:32], OLDV[95:64], OLDV[127:96]})
      $display("FAIL squash_ram rst=%0b got %0h %0h %0h %0h exp a5a50001 a5a50002 0f0f0f03 0f0f0f04",
               use_reset, ram[base], ram[base+12'd1], ram[base+12'd2], ram[base+12'd3]);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_alu_s();
    test_flush_idle_and_bubble();
    test_alu_v();
    test_scalar_mem();
    test_vector_store_load();
    test_wrap();
    test_squash(12'h020, 1'b0);
    test_squash(12'h030, 1'b1);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
